layer_sched: RTL and testbench

Programmable layer scheduler for the LeNet accelerator. It holds a 16-entry stage program and sequences the conv, relu and max-pool engines one at a time through it. It produces the per-engine enables and the select for the shared DRAM-port mux, and counts completed layers. A per-layer watchdog traps hung engines, and an abort returns the block to idle from any state.

---
 rtl/layer_sched.sv | 200 ++++++++++++++++++++
 tb/tb_layer_sched.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_sched.sv
// -----------------------------------------------------------------------------
// layer_sched
//
// Programmable layer scheduler for the LeNet accelerator. A 16-entry stage
// program selects which engine (conv, relu, pool) runs next. The engines run
// one at a time. For each layer the block raises that engine's enable, steers
// the shared DRAM-port mux, and counts completed layers. A per-layer watchdog
// traps a hung engine in ERR. Abort returns to IDLE from any state.
//
// Ports:
//   clk            rising-edge clock
//   srstn          asynchronous active-low reset
//   start          level; starts the program from entry 0 in IDLE or DONE
//   abort          forces IDLE on the next cycle from any state
//   cfg_we         program-table write strobe (honoured in IDLE, DONE, ERR)
//   cfg_addr       program-table entry index
//   cfg_op         opcode: 0 CONV, 1 RELU, 2 POOL, 3 END
//   rdy_data       input-data ready, registered internally as rdy_ff
//   eng_done       one-cycle done pulses from the engines
//   eng_en         engine enables, at most one bit high, only in RUN
//   eng_sel        registered DRAM mux select (the current opcode)
//   cur_stage      current program pointer
//   busy           high in LOAD, WAIT_RDY and RUN
//   done           high while in DONE
//   done_one_layer one-cycle pulse per completed layer
//   err_timeout    high while in ERR
// -----------------------------------------------------------------------------
module layer_sched #(
  parameter int NUM_ENG    = 3,
  parameter int TBL_DEPTH  = 16,
  parameter int WDOG_WIDTH = 20
) (
  input  logic               clk,
  input  logic               srstn,
  input  logic               start,
  input  logic               abort,
  input  logic               cfg_we,
  input  logic [3:0]         cfg_addr,
  input  logic [1:0]         cfg_op,
  input  logic               rdy_data,
  input  logic [NUM_ENG-1:0] eng_done,
  output logic [NUM_ENG-1:0] eng_en,
  output logic [1:0]         eng_sel,
  output logic [3:0]         cur_stage,
  output logic               busy,
  output logic               done,
  output logic               done_one_layer,
  output logic               err_timeout
);

  typedef enum logic [1:0] {
    OP_CONV = 2'd0,
    OP_RELU = 2'd1,
    OP_POOL = 2'd2,
    OP_END  = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_RDY,
    S_RUN,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [3:0] PTR_LAST = 4'(TBL_DEPTH - 1);
  // The layer has used up its budget when this cycle's increment would make the
  // counter all-ones.
  localparam logic [WDOG_WIDTH-1:0] WDOG_LAST = ~WDOG_WIDTH'(1);

  // Power-on program: CONV, RELU, POOL, CONV, RELU, POOL, then END.
  function automatic op_t default_op(input int idx);
    if (idx < 6) return op_t'(2'(idx % 3));
    return OP_END;
  endfunction

  state_t                state_q, state_d;
  logic [3:0]            ptr_q, ptr_d;
  logic [1:0]            sel_q, sel_d;
  logic [WDOG_WIDTH-1:0] wdog_q, wdog_d;
  logic                  dol_q, dol_d;
  logic                  rdy_ff;
  logic                  sel_done;
  logic                  cfg_ok;
  op_t                   tbl_q [TBL_DEPTH];

  // Only the selected engine's done pulse counts. Pulses from the other
  // engines are ignored.
  always_comb begin
    sel_done = 1'b0;
    if (int'(sel_q) < NUM_ENG) sel_done = eng_done[sel_q];
  end

  // Reprogramming is allowed only while no layer is in flight.
  assign cfg_ok = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);

  // NOTE: every signal is assigned a default before the case statement. An
  // unassigned path in combinational logic would infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    wdog_d  = wdog_q;
    dol_d   = 1'b0;

    if (abort) begin
      // Abort overrides everything, including a done pulse in the same cycle.
      state_d = S_IDLE;
      ptr_d   = '0;
      wdog_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d = S_LOAD;
            ptr_d   = '0;
          end
        end
        S_LOAD: begin
          if (tbl_q[ptr_q] == OP_END) begin
            state_d = S_DONE;
          end else begin
            sel_d   = tbl_q[ptr_q];
            state_d = S_WAIT_RDY;
          end
        end
        S_WAIT_RDY: begin
          if (rdy_ff) begin
            state_d = S_RUN;
            wdog_d  = '0;
          end
        end
        S_RUN: begin
          wdog_d = wdog_q + WDOG_WIDTH'(1);
          // A done pulse takes priority over a watchdog expiry in the same cycle.
          if (sel_done) begin
            dol_d = 1'b1;
            if (ptr_q == PTR_LAST) begin
              state_d = S_DONE;
            end else begin
              ptr_d   = ptr_q + 4'd1;
              state_d = S_LOAD;
            end
          end else if (wdog_q == WDOG_LAST) begin
            state_d = S_ERR;
          end
        end
        S_ERR: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. Every flop then
  // samples the values from before this clock edge, whatever order the blocks
  // run in.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      wdog_q  <= '0;
      dol_q   <= 1'b0;
      rdy_ff  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      wdog_q  <= wdog_d;
      dol_q   <= dol_d;
      rdy_ff  <= rdy_data;
    end
  end

  // NOTE: the program table is deliberately built from resettable flops, not
  // RAM. Reset must restore the default program without any software reload.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      for (int i = 0; i < TBL_DEPTH; i++) tbl_q[i] <= default_op(i);
    end else if (cfg_we && cfg_ok) begin
      tbl_q[cfg_addr] <= op_t'(cfg_op);
    end
  end

  // The enable follows rdy_ff while in RUN. A ready drop therefore gates the
  // engine one cycle later, and the layer stays in RUN.
  always_comb begin
    eng_en = '0;
    if ((state_q == S_RUN) && (int'(sel_q) < NUM_ENG)) eng_en[sel_q] = rdy_ff;
  end

  assign eng_sel        = sel_q;
  assign cur_stage      = ptr_q;
  assign busy           = (state_q == S_LOAD) || (state_q == S_WAIT_RDY) || (state_q == S_RUN);
  assign done           = (state_q == S_DONE);
  assign err_timeout    = (state_q == S_ERR);
  assign done_one_layer = dol_q;

endmodule

// File: tb/tb_layer_sched.sv
// -----------------------------------------------------------------------------
// tb_layer_sched
//
// Self-checking bench for layer_sched, built with a 4-bit watchdog. A
// behavioural model of the scheduler advances once per clock. It holds the
// program as an int array and the layer's elapsed RUN cycles as an int, and
// every output is compared with it on each falling edge. The directed phases
// cover the default program, rdy gating, watchdog, abort, reprogramming and
// async reset. A randomized phase follows.
// -----------------------------------------------------------------------------
module tb_layer_sched;

  localparam int WDW      = 4;
  localparam int WD_LIMIT = (1 << WDW) - 1;   // RUN cycles allowed without done

  logic       clk = 1'b0;
  logic       srstn;
  logic       start, abort, cfg_we, rdy_data;
  logic [3:0] cfg_addr;
  logic [1:0] cfg_op;
  logic [2:0] eng_done;
  logic [2:0] eng_en;
  logic [1:0] eng_sel;
  logic [3:0] cur_stage;
  logic       busy, done, done_one_layer, err_timeout;

  layer_sched #(.NUM_ENG(3), .TBL_DEPTH(16), .WDOG_WIDTH(WDW)) dut (
    .clk            (clk),
    .srstn          (srstn),
    .start          (start),
    .abort          (abort),
    .cfg_we         (cfg_we),
    .cfg_addr       (cfg_addr),
    .cfg_op         (cfg_op),
    .rdy_data       (rdy_data),
    .eng_done       (eng_done),
    .eng_en         (eng_en),
    .eng_sel        (eng_sel),
    .cur_stage      (cur_stage),
    .busy           (busy),
    .done           (done),
    .done_one_layer (done_one_layer),
    .err_timeout    (err_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef enum int {M_IDLE, M_LOAD, M_WAIT, M_RUN, M_DONE, M_ERR} mstate_t;

  mstate_t m_state;
  int      m_tbl [16];
  int      m_ptr, m_sel, m_runs;
  bit      m_rdy, m_dol;

  function automatic int default_op(input int i);
    return (i < 6) ? (i % 3) : 3;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_tbl[i] = default_op(i);
    m_state = M_IDLE;
    m_ptr   = 0;
    m_sel   = 0;
    m_runs  = 0;
    m_rdy   = 0;
    m_dol   = 0;
  endtask

  task automatic model_step();
    mstate_t ns;
    int      np, nsel, nruns;
    bit      ndol, wr_ok;
    if (!srstn) begin
      m_reset();
      return;
    end
    ns    = m_state;
    np    = m_ptr;
    nsel  = m_sel;
    nruns = m_runs;
    ndol  = 0;
    wr_ok = (m_state == M_IDLE) || (m_state == M_DONE) || (m_state == M_ERR);
    if (abort) begin
      ns = M_IDLE; np = 0; nruns = 0;
    end else begin
      case (m_state)
        M_IDLE, M_DONE: if (start) begin ns = M_LOAD; np = 0; end
        M_LOAD: begin
          if (m_tbl[m_ptr] == 3) ns = M_DONE;
          else begin nsel = m_tbl[m_ptr]; ns = M_WAIT; end
        end
        M_WAIT: if (m_rdy) begin ns = M_RUN; nruns = 0; end
        M_RUN: begin
          nruns = m_runs + 1;
          if (eng_done[m_sel]) begin
            ndol = 1;
            if (m_ptr == 15) ns = M_DONE;
            else begin np = m_ptr + 1; ns = M_LOAD; end
          end else if (nruns == WD_LIMIT) begin
            ns = M_ERR;
          end
        end
        default: ;
      endcase
    end
    if (cfg_we && wr_ok) m_tbl[cfg_addr] = int'(cfg_op);
    m_state = ns;
    m_ptr   = np;
    m_sel   = nsel;
    m_runs  = nruns;
    m_dol   = ndol;
    m_rdy   = rdy_data;
  endtask

  task automatic check_outputs();
    logic [2:0] exp_en;
    exp_en = (m_state == M_RUN && m_rdy) ? 3'(1 << m_sel) : 3'b000;
    check("eng_en",         eng_en,         exp_en);
    check("eng_sel",        eng_sel,        m_sel);
    check("cur_stage",      cur_stage,      m_ptr);
    check("busy",           busy,           (m_state == M_LOAD || m_state == M_WAIT || m_state == M_RUN));
    check("done",           done,           (m_state == M_DONE));
    check("done_one_layer", done_one_layer, m_dol);
    check("err_timeout",    err_timeout,    (m_state == M_ERR));
  endtask

  // ---------------------------------------------------------------------------
  // Engine agent: it follows the model, not the DUT. The selected engine
  // returns done `lat` cycles after its layer enters RUN. The other engines
  // emit random noise pulses.
  // ---------------------------------------------------------------------------
  bit agent_on    = 0;
  int lat         = 10;
  int abort_layer = -1;

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    if (agent_on) begin
      eng_done = 3'b000;
      if ($urandom_range(0, 3) == 0) eng_done = 3'($urandom) & ~3'(1 << m_sel);
      if (m_state == M_RUN && m_runs == lat) begin
        eng_done[m_sel] = 1'b1;
        if (abort_layer >= 0 && m_ptr == abort_layer) abort = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic run_to_done(input string tag, input int max_cycles);
    int k = 0;
    while (m_state != M_DONE && k < max_cycles) begin
      cycle();
      k++;
    end
    check({tag, "_bound"}, (k < max_cycles), 1);
    check({tag, "_done"}, done, 1);
  endtask

  task automatic wait_run(input string tag, input int idx, input int max_cycles);
    int k = 0;
    while (!(m_state == M_RUN && m_runs == idx) && k < max_cycles) begin
      cycle();
      k++;
    end
    check({tag, "_bound"}, (k < max_cycles), 1);
  endtask

  // Observation of DUT activity, used only for the per-test summaries.
  logic [2:0] prev_en = 3'b000;
  int         en_seq[$];
  int         dol_cnt = 0;

  always @(negedge clk) begin
    if (eng_en != 3'b000 && eng_en != prev_en) en_seq.push_back(int'(eng_en));
    prev_en = eng_en;
    if (done_one_layer === 1'b1) dol_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_seq[6] = '{1, 2, 4, 1, 2, 4};
    int gap, j;

    srstn = 1'b1; start = 0; abort = 0; cfg_we = 0; cfg_addr = '0; cfg_op = '0;
    rdy_data = 1'b1; eng_done = '0;
    m_reset();
    #1 srstn = 1'b0;
    #2;
    check_outputs();
    repeat (2) cycle();
    srstn = 1'b1;
    cycle();

    // ---- Default program ----
    agent_on = 1; lat = 10;
    en_seq.delete(); dol_cnt = 0;
    start = 1; cycle(); start = 0;
    run_to_done("default", 200);
    check("default_layers", dol_cnt, 6);
    check("default_stage", cur_stage, 6);
    check("default_en_count", en_seq.size(), 6);
    for (int i = 0; i < 6 && i < en_seq.size(); i++)
      check($sformatf("default_en_seq%0d", i), en_seq[i], exp_seq[i]);
    repeat (3) cycle();
    check("default_done_hold", done, 1);

    // ---- rdy gating in the middle of a RUN ----
    start = 1; cycle(); start = 0;
    wait_run("gate_wait", 2, 50);
    rdy_data = 1'b0;
    gap = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (eng_en == 3'b000) gap++;
      check("gate_busy", busy, 1);
    end
    rdy_data = 1'b1;
    cycle();
    if (eng_en == 3'b000) gap++;
    check("gate_en_back", eng_en, 3'b001);
    check("gate_low_cycles", gap, 5);
    run_to_done("gate", 200);

    // ---- Abort together with eng_done in the second layer ----
    dol_cnt = 0;
    abort_layer = 1;
    start = 1; cycle(); start = 0;
    j = 0;
    while (abort == 1'b0 && j < 100) begin cycle(); j++; end
    check("abort_bound", (j < 100), 1);
    check("abort_dol", done_one_layer, 0);
    check("abort_stage", cur_stage, 0);
    check("abort_busy", busy, 0);
    check("abort_en", eng_en, 0);
    abort = 0; abort_layer = -1;
    cycle();
    check("abort_layers", dol_cnt, 1);

    // ---- Reprogram: a write while busy is ignored, a write in DONE lands ----
    dol_cnt = 0;
    start = 1; cycle(); start = 0;
    cycle();
    cfg_we = 1; cfg_addr = 4'd1; cfg_op = 2'd3;
    cycle();
    cfg_we = 0;
    run_to_done("reprog_busy", 200);
    check("reprog_busy_layers", dol_cnt, 6);
    cfg_we = 1; cfg_addr = 4'd1; cfg_op = 2'd3;
    cycle();
    cfg_we = 0;
    dol_cnt = 0;
    start = 1; cycle(); start = 0;
    run_to_done("reprog_done", 100);
    check("reprog_layers", dol_cnt, 1);
    check("reprog_stage", cur_stage, 1);

    // ---- Asynchronous reset between clock edges mid-RUN ----
    start = 1; cycle(); start = 0;
    wait_run("areset_wait", 3, 50);
    check("areset_pre_en", eng_en, 3'b001);
    #2 srstn = 1'b0;
    #1;
    check("areset_en", eng_en, 0);
    check("areset_sel", eng_sel, 0);
    check("areset_stage", cur_stage, 0);
    check("areset_busy", busy, 0);
    check("areset_done", done, 0);
    check("areset_dol", done_one_layer, 0);
    check("areset_err", err_timeout, 0);
    m_reset();
    repeat (2) cycle();
    srstn = 1'b1;
    dol_cnt = 0;
    start = 1; cycle(); start = 0;
    run_to_done("areset_table", 200);
    check("areset_table_layers", dol_cnt, 6);
    check("areset_table_stage", cur_stage, 6);

    // ---- Watchdog: conv never finishes ----
    lat = -1;
    start = 1; cycle(); start = 0;
    j = 1;
    while (err_timeout !== 1'b1 && j < 40) begin cycle(); j++; end
    check("wdog_latency", j, 3 + WD_LIMIT);
    repeat (5) cycle();
    check("wdog_hold", err_timeout, 1);
    check("wdog_en", eng_en, 0);
    abort = 1; cycle(); abort = 0;
    check("wdog_abort_err", err_timeout, 0);
    check("wdog_abort_busy", busy, 0);
    lat = 10;

    // ---- Randomized traffic ----
    agent_on = 0;
    for (int n = 0; n < 4000; n++) begin
      start    = ($urandom_range(0, 9) == 0);
      abort    = ($urandom_range(0, 79) == 0);
      cfg_we   = ($urandom_range(0, 11) == 0);
      cfg_addr = 4'($urandom);
      cfg_op   = 2'($urandom);
      rdy_data = ($urandom_range(0, 3) != 0);
      for (int b = 0; b < 3; b++) eng_done[b] = ($urandom_range(0, 5) == 0);
      cycle();
    end
    start = 0; abort = 0; cfg_we = 0; eng_done = '0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
